instr_fetch_bp: RTL and testbench
=================================

// Module: instr_fetch_bp
// PURPOSE
//  Parametrised fetch stage: owns the PC and drives the instruction-memory address.
//  Uses an internal direct-mapped BTB with 2-bit saturating counters for next-PC prediction.
//  Accepts redirects from execute (mispredict/jalr) and BTB training updates; supports stall.
//  Sits between instruction memory and the decode-stage register.
// PARAMETERS
//  XLEN        32            address/instruction width (>=32)
//  RESET_PC    32'h0000_0000 PC value loaded on reset
//  BTB_ENTRIES 16            BTB depth; power of two, >=2; IDX = log2(BTB_ENTRIES)
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  rst            in   1     synchronous, active-high reset
//  stall          in   1     hold PC and outputs (decode not ready)
//  redirect_valid in   1     execute-stage correction this cycle
//  redirect_pc    in   XLEN  corrected target; bits[1:0] ignored (forced 0)
//  upd_valid      in   1     BTB training request from resolved branch/jump
//  upd_pc         in   XLEN  PC of the resolved branch
//  upd_taken      in   1     resolved direction
//  upd_target     in   XLEN  resolved target
//  imem_addr      out  XLEN  = PC (combinational)
//  imem_rdata     in   XLEN  instruction word at imem_addr, same-cycle read
//  if_valid       out  1     if_instr/if_pc are a valid fetch this cycle
//  if_pc          out  XLEN  current PC
//  if_pc_4        out  XLEN  PC + 4, modulo 2^XLEN
//  if_instr       out  XLEN  = imem_rdata
//  if_pred_taken  out  1     BTB hit and counter[1]==1
//  if_pred_pc     out  XLEN  predicted next PC (target if pred_taken, else PC+4)
// BEHAVIOUR
//  Reset: PC<=RESET_PC; all BTB valid<=0, counters<=2'b01; if_valid=0 in the reset cycle.
//  Reset wins over redirect/stall/update in the same cycle.
//  Lookup (combinational): idx=PC[IDX+1:2], tag=PC[XLEN-1:IDX+2]; hit=valid[idx]&&tag match.
//  Next-PC priority: rst > redirect_valid ({redirect_pc[XLEN-1:2],2'b00}) > stall (hold PC)
//    > pred_taken (BTB target) > PC+4.
//  if_valid = !rst && !redirect_valid (current fetch is wrong-path when redirecting).
//  Stall: PC, if_* outputs stable; BTB updates still apply.
//  Latency: redirect_valid in cycle N -> if_pc==redirect_pc, if_valid=1 in cycle N+1.
//  BTB update (posedge, when upd_valid && !rst), index/tag taken from upd_pc:
//    tag hit: counter saturating +1 if taken, -1 if not (limits 00/11); target<=upd_target if taken.
//    tag miss & taken: allocate/replace: valid=1, tag, target, counter=2'b10.
//    tag miss & not taken: no change.
//  Same-cycle update and lookup of one index: lookup sees pre-update contents (write-after-read).
//  PC+4 and all PC arithmetic wrap modulo 2^XLEN; no exception on wrap.
//  Targets stored unmodified; stored target[1:0] forced 0 on write.
// STRUCTURE
//  Shared package/include fetch_pkg: XLEN default, counter encodings (SNT=00,WNT=01,WT=10,ST=11),
//    BTB entry field widths derived from BTB_ENTRIES.
//  One sub-module: btb (lookup port + update port, counter logic, valid/tag/target arrays).
//  Top: PC register, next-PC mux, output assignments.
// TESTING
//  1 Reset, no BTB hits, 4 cycles -> if_pc 0,4,8,12; if_pred_taken=0; if_valid=1 after reset.
//  2 upd(pc=0x10,taken,target=0x40); later fetch 0x10 -> pred_taken=1, next if_pc=0x40.
//  3 Train 0x10 taken, then not-taken x2 -> counter 10->01->00; fetch 0x10 predicts 0x14.
//  4 stall=1 for 3 cycles at PC=0x8 -> if_pc stays 0x8; redirect_valid(0x103) during stall
//    -> if_valid=0 that cycle, next if_pc=0x100.
//  5 Alias: entries 0x10 and 0x10+4*BTB_ENTRIES both taken -> second replaces first; 0x10 misses.
//  6 rst asserted mid-run with redirect_valid and upd_valid -> PC=RESET_PC, BTB empty, no alloc.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the fetch stage: default widths, the 2-bit
//   branch-direction counter encoding, and helpers that derive BTB field
//   widths from the BTB depth.
package fetch_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int BTB_ENTRIES_DEF = 16;

  // Direction counter: strongly/weakly not-taken, weakly/strongly taken.
  // Bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  // Index width: PC word-address bits used to select a BTB entry.
  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Tag width: everything above the index and the two byte-offset bits.
  function automatic int btb_tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/instr_fetch_bp_btb.sv
// instr_fetch_bp_btb
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry.
// Ports
//   clk, rst            clock, synchronous active-high reset (clears valid,
//                       counters to weakly not-taken)
//   lk_pc               lookup PC (current fetch)
//   lk_taken            lookup hit and counter predicts taken
//   lk_target           stored target of the indexed entry
//   up_valid            training request
//   up_pc/up_taken/up_target  resolved branch PC, direction and target
module instr_fetch_bp_btb
  import fetch_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            up_valid,
  input  logic [XLEN-1:0] up_pc,
  input  logic            up_taken,
  input  logic [XLEN-1:0] up_target
);

  localparam int IDX   = btb_idx_w(BTB_ENTRIES);
  localparam int TAG_W = btb_tag_w(XLEN, BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] r_valid;
  cnt_e                   r_cnt [BTB_ENTRIES];
  logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        r_tgt [BTB_ENTRIES];

  logic [IDX-1:0]   w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX-1:0]   w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_alloc;
  logic             w_train;
  logic             w_wr_tgt;
  logic             w_unused_bits;

  function automatic cnt_e cnt_inc(input cnt_e c);
    case (c)
      CNT_SNT: return CNT_WNT;
      CNT_WNT: return CNT_WT;
      default: return CNT_ST;
    endcase
  endfunction

  function automatic cnt_e cnt_dec(input cnt_e c);
    case (c)
      CNT_ST:  return CNT_WT;
      CNT_WT:  return CNT_WNT;
      default: return CNT_SNT;
    endcase
  endfunction

  // Lookup reads the registered arrays directly, so a same-cycle update to
  // the same index is only visible from the next cycle on.
  assign w_lk_idx  = lk_pc[IDX+1:2];
  assign w_lk_tag  = lk_pc[XLEN-1:IDX+2];
  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign lk_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
  assign lk_target = r_tgt[w_lk_idx];

  assign w_up_idx = up_pc[IDX+1:2];
  assign w_up_tag = up_pc[XLEN-1:IDX+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // A not-taken miss is dropped: allocating it would only evict something.
  assign w_alloc  = up_valid && !rst && !w_up_hit && up_taken;
  assign w_train  = up_valid && !rst && w_up_hit;
  assign w_wr_tgt = w_alloc || (w_train && up_taken);

  assign w_unused_bits = &{1'b0, lk_pc[1:0], up_pc[1:0], up_target[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) r_cnt[i] <= CNT_WNT;
    end else if (w_alloc) begin
      r_valid[w_up_idx] <= 1'b1;
      r_cnt[w_up_idx]   <= CNT_WT;
    end else if (w_train) begin
      r_cnt[w_up_idx] <= up_taken ? cnt_inc(r_cnt[w_up_idx])
                                  : cnt_dec(r_cnt[w_up_idx]);
    end
  end

  // Tag/target storage carries no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_wr_tgt) r_tgt[w_up_idx] <= {up_target[XLEN-1:2], 2'b00};
    if (w_alloc)  r_tag[w_up_idx] <= w_up_tag;
  end

endmodule

// File: rtl/instr_fetch_bp.sv
// instr_fetch_bp
//   Fetch stage: owns the PC, drives the instruction-memory address and
//   predicts the next PC through an internal BTB.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   stall                       hold PC (decode not ready)
//   redirect_valid/redirect_pc  execute-stage correction (bits[1:0] dropped)
//   upd_valid/upd_pc/upd_taken/upd_target  BTB training from resolved branch
//   imem_addr, imem_rdata       instruction memory, same-cycle read
//   if_valid, if_pc, if_pc_4, if_instr      fetch result to decode
//   if_pred_taken, if_pred_pc   BTB prediction for the current PC
module instr_fetch_bp
  import fetch_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = BTB_ENTRIES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_4,
  output logic [XLEN-1:0] if_instr,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_pc
);

  logic [XLEN-1:0] r_pc_p0;
  logic [XLEN-1:0] w_pc_4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;
  logic [XLEN-1:0] w_pred_pc;

  instr_fetch_bp_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lk_pc     (r_pc_p0),
    .lk_taken  (w_pred_taken),
    .lk_target (w_pred_target),
    .up_valid  (upd_valid),
    .up_pc     (upd_pc),
    .up_taken  (upd_taken),
    .up_target (upd_target)
  );

  // PC arithmetic wraps naturally at XLEN bits.
  assign w_pc_4    = r_pc_p0 + XLEN'(4);
  assign w_pred_pc = w_pred_taken ? w_pred_target : w_pc_4;

  always_comb begin
    w_next_pc = w_pred_pc;
    if (redirect_valid) w_next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    else if (stall)     w_next_pc = r_pc_p0;
  end

  // Stage p0: PC register.
  always_ff @(posedge clk) begin
    if (rst) r_pc_p0 <= RESET_PC;
    else     r_pc_p0 <= w_next_pc;
  end

  // A redirect marks the instruction fetched this cycle as wrong-path.
  assign imem_addr     = r_pc_p0;
  assign if_valid      = !rst && !redirect_valid;
  assign if_pc         = r_pc_p0;
  assign if_pc_4       = w_pc_4;
  assign if_instr      = imem_rdata;
  assign if_pred_taken = w_pred_taken;
  assign if_pred_pc    = w_pred_pc;

endmodule

// File: tb/tb_instr_fetch_bp.sv
module tb_instr_fetch_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic [31:0] if_instr;
  logic        if_pred_taken;
  logic [31:0] if_pred_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: data word derived from the address.
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  instr_fetch_bp #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_4        (if_pc_4),
    .if_instr       (if_instr),
    .if_pred_taken  (if_pred_taken),
    .if_pred_pc     (if_pred_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Redirect to pc; returns one cycle later with redirect released.
  task automatic jump(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    step(); step();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", if_valid); end
    n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 00000000", if_pc); end
    rst = 1'b0; #1;
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_valid got %b want 1", if_valid); end
    n_vec++; if (if_instr !== 32'hDEAD_0000) begin n_err++; $display("FAIL instr got %h want dead0000", if_instr); end
    n_vec++; if (if_pc_4 !== 32'h4) begin n_err++; $display("FAIL pc_4 got %h want 00000004", if_pc_4); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL seq_pred pc=%h got %b want 0", if_pc, if_pred_taken); end
      step();
      exp_pc = exp_pc + 32'h4;
      n_vec++; if (if_pc !== exp_pc) begin n_err++; $display("FAIL seq_pc got %h want %h", if_pc, exp_pc); end
    end
  endtask

  // PC is 0xC on entry.
  task automatic test_btb_alloc();
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h40;
    step();
    upd_valid = 1'b0; #1;
    n_vec++; if (if_pc !== 32'h10) begin n_err++; $display("FAIL alloc_pc got %h want 00000010", if_pc); end
    n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_pred got %b want 1", if_pred_taken); end
    n_vec++; if (if_pred_pc !== 32'h40) begin n_err++; $display("FAIL alloc_pred_pc got %h want 00000040", if_pred_pc); end
    step();
    n_vec++; if (if_pc !== 32'h40) begin n_err++; $display("FAIL alloc_follow got %h want 00000040", if_pc); end
  endtask

  task automatic test_counter();
    // 10 -> 01 -> 00
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0; upd_target = 32'h0;
    step(); step();
    upd_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redirect_valid got %b want 0", if_valid); end
    step();
    redirect_valid = 1'b0; #1;
    n_vec++; if (if_pc !== 32'h10) begin n_err++; $display("FAIL redirect_pc got %h want 00000010", if_pc); end
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL cnt00_pred got %b want 0", if_pred_taken); end
    n_vec++; if (if_pred_pc !== 32'h14) begin n_err++; $display("FAIL cnt00_pred_pc got %h want 00000014", if_pred_pc); end
    step();
    n_vec++; if (if_pc !== 32'h14) begin n_err++; $display("FAIL cnt00_next got %h want 00000014", if_pc); end
    // 00 -> 01 (target 0x80), then one more taken -> 10
    upd_valid = 1'b1; upd_taken = 1'b1; upd_target = 32'h80;
    step();
    upd_valid = 1'b0;
    jump(32'h10);
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL cnt01_pred got %b want 0", if_pred_taken); end
    // 01 -> 10 -> 11 -> 11, then not-taken -> 10
    upd_valid = 1'b1; upd_taken = 1'b1;
    step(); step(); step();
    upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    jump(32'h10);
    n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL cnt_sat_pred got %b want 1", if_pred_taken); end
    n_vec++; if (if_pred_pc !== 32'h80) begin n_err++; $display("FAIL cnt_sat_tgt got %h want 00000080", if_pred_pc); end
    step();
    n_vec++; if (if_pc !== 32'h80) begin n_err++; $display("FAIL cnt_sat_next got %h want 00000080", if_pc); end
  endtask

  task automatic test_stall();
    jump(32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (if_pc !== 32'h8) begin n_err++; $display("FAIL stall_pc cyc%0d got %h want 00000008", i, if_pc); end
      n_vec++; if (if_instr !== 32'hDEAD_0008) begin n_err++; $display("FAIL stall_instr got %h want dead0008", if_instr); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stall_redir_valid got %b want 0", if_valid); end
    step();
    redirect_valid = 1'b0; stall = 1'b0; #1;
    n_vec++; if (if_pc !== 32'h100) begin n_err++; $display("FAIL stall_redir_pc got %h want 00000100", if_pc); end
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_redir_valid1 got %b want 1", if_valid); end
  endtask

  task automatic test_alias();
    upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'h200;
    step();
    upd_valid = 1'b0;
    jump(32'h10);
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_old_pred got %b want 0", if_pred_taken); end
    n_vec++; if (if_pred_pc !== 32'h14) begin n_err++; $display("FAIL alias_old_pc got %h want 00000014", if_pred_pc); end
    jump(32'h50);
    n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_pred got %b want 1", if_pred_taken); end
    n_vec++; if (if_pred_pc !== 32'h200) begin n_err++; $display("FAIL alias_new_pc got %h want 00000200", if_pred_pc); end
  endtask

  task automatic test_war_and_wrap();
    jump(32'h30);
    upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1; upd_target = 32'h93; #1;
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL war_pred got %b want 0", if_pred_taken); end
    step();
    upd_valid = 1'b0; #1;
    n_vec++; if (if_pc !== 32'h34) begin n_err++; $display("FAIL war_next got %h want 00000034", if_pc); end
    jump(32'h30);
    n_vec++; if (if_pred_pc !== 32'h90) begin n_err++; $display("FAIL tgt_align got %h want 00000090", if_pred_pc); end
    jump(32'hFFFF_FFFC);
    n_vec++; if (if_pc_4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h want 00000000", if_pc_4); end
    step();
    n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 00000000", if_pc); end
  endtask

  task automatic test_reset_priority();
    jump(32'h40);
    rst = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h300; #1;
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", if_valid); end
    step();
    rst = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0; #1;
    n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_mid_pc got %h want 00000000", if_pc); end
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_valid1 got %b want 1", if_valid); end
    jump(32'h50);
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_clear_50 got %b want 0", if_pred_taken); end
    jump(32'h30);
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_clear_30 got %b want 0", if_pred_taken); end
    jump(32'h20);
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_no_alloc got %b want 0", if_pred_taken); end
  endtask

  initial begin
    test_reset();
    test_btb_alloc();
    test_counter();
    test_stall();
    test_alias();
    test_war_and_wrap();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
